// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmitter; power-of-two DEPTH, one extra
// pointer bit distinguishes full from empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  // A push is judged against the current full flag, so a same-cycle pop never makes room.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte sink, FIFO, 8N1 frames (8E1 when
// UART_TX_PARITY_EN is defined), gap-free back-to-back frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  uart_tx_state_t              state;
  logic [CNT_W-1:0]            baud_cnt;
  logic [IDX_W-1:0]            bit_idx;
  logic [UART_DATA_BITS-1:0]   shift;
  logic [UART_DATA_BITS-1:0]   fifo_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        baud_done;
  logic                        pop;
`ifdef UART_TX_PARITY_EN
  logic                        parity_q;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign baud_done = (baud_cnt == CNT_LAST);
  assign tx_ready  = !fifo_full;
  assign tx_busy   = (state != IDLE) || !fifo_empty;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pop = 1'b0;
    if (state == IDLE || (state == STOP && baud_done)) pop = !fifo_empty;
  end

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      tx_serial <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (pop) begin
        shift   <= fifo_data;
        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^fifo_data;
`endif
      end

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= START;
            baud_cnt  <= '0;
            tx_serial <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            state     <= DATA;
            baud_cnt  <= '0;
            tx_serial <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              state     <= PARITY;
              tx_serial <= parity_q;
`else
              state     <= STOP;
              tx_serial <= UART_IDLE_LEVEL;
`endif
            end else begin
              shift     <= {1'b0, shift[UART_DATA_BITS-1:1]};
              bit_idx   <= bit_idx + 1'b1;
              tx_serial <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            state     <= STOP;
            baud_cnt  <= '0;
            tx_serial <= UART_IDLE_LEVEL;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              state     <= START;
              tx_serial <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at CLKS_PER_BIT=4, one at 2,
// expected line waveforms built from hand-chosen bytes.
module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int CPB2 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FL  = FRAME_BITS * CPB;
  localparam int FL2 = FRAME_BITS * CPB2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_serial, tx_busy;
  logic [7:0] tx_data2 = '0;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx_serial2, tx_busy2;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] cap_q[$];
  bit         cap_en = 1'b0;

  logic [10:0] v;
  logic        st;
  logic [7:0]  stream [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
  int          pop_e;
  int          lows;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_busy(tx_busy)
  );

  uart_tx #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_serial(tx_serial2), .tx_busy(tx_busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cap_en) cap_q.push_back({tx_serial2, tx_serial});
  endtask

  // Frame bits LSB first: start, d0..d7, [parity], stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f      = '0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  task automatic get_frame(input int start, input int cpb, input int which,
                           output logic [10:0] fv, output logic stable);
    logic [1:0] smp;
    int idx;
    fv = '0;
    stable = 1'b1;
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < cpb; c++) begin
        idx = start + b * cpb + c;
        smp = (idx < cap_q.size()) ? cap_q[idx] : 2'bxx;
        if (c == 0) fv[b] = smp[which];
        else if (smp[which] !== fv[b]) stable = 1'b0;
      end
    end
  endtask

  task automatic send_one(input logic [7:0] d, input string tag);
    logic [10:0] fv;
    logic        fs;
    cap_q.delete();
    cap_en   = 1'b1;
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    check({tag, "_idle_before"}, tx_serial, 1'b1);
    check({tag, "_busy_on"}, tx_busy, 1'b1);
    repeat (FL) step();
    check({tag, "_busy_in_stop"}, tx_busy, 1'b1);
    step();
    check({tag, "_busy_off"}, tx_busy, 1'b0);
    check({tag, "_line_idle"}, tx_serial, 1'b1);
    get_frame(1, CPB, 0, fv, fs);
    check({tag, "_frame"}, fv, exp_frame(d));
    check({tag, "_bit_width"}, fs, 1'b1);
    cap_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    step();
    check("rst_serial", tx_serial, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_serial2", tx_serial2, 1'b1);
    rst = 1'b0;
    step();

    send_one(8'h55, "byte55");
    send_one(8'h07, "byte07");

    // Five consecutive pushes plus a sixth byte held valid while full
    cap_q.delete();
    cap_en = 1'b1;
    pop_e  = FL + 2;
    for (int e = 1; e <= 6 * FL + 2; e++) begin
      if (e <= 5) begin
        tx_valid = 1'b1;
        tx_data  = stream[e-1];
      end else if (e <= pop_e + 1) begin
        tx_valid = 1'b1;
        tx_data  = stream[5];
      end else begin
        tx_valid = 1'b0;
      end
      step();
      if (e == 4)         check("stream_ready_e4", tx_ready, 1'b1);
      if (e == 5)         check("stream_full_e5", tx_ready, 1'b0);
      if (e == pop_e - 1) check("stream_held_refused", tx_ready, 1'b0);
      if (e == pop_e)     check("stream_slot_freed", tx_ready, 1'b1);
      if (e == pop_e + 1) check("stream_full_again", tx_ready, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      get_frame(1 + k * FL, CPB, 0, v, st);
      check($sformatf("stream_frame%0d", k), v, exp_frame(stream[k]));
      check($sformatf("stream_width%0d", k), st, 1'b1);
    end
    check("stream_busy_end", tx_busy, 1'b0);
    repeat (2 * CPB) step();
    check("stream_no_dup", tx_busy, 1'b0);
    cap_en = 1'b0;

    // Reset 10 cycles into a 0x3C frame with 0x11, 0x22 queued
    for (int e = 1; e <= 11; e++) begin
      tx_valid = (e <= 3);
      tx_data  = (e == 1) ? 8'h3C : (e == 2) ? 8'h11 : 8'h22;
      step();
    end
    check("pre_rst_bit1_of_3c", tx_serial, 1'b0);
    check("pre_rst_busy", tx_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_serial", tx_serial, 1'b1);
    check("mid_rst_ready", tx_ready, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    cap_q.delete();
    cap_en = 1'b1;
    repeat (60) step();
    lows = 0;
    foreach (cap_q[i]) if (cap_q[i][0] !== 1'b1) lows++;
    check("post_rst_silent", lows, 0);
    check("post_rst_busy", tx_busy, 1'b0);
    cap_en = 1'b0;
    send_one(8'h5A, "after_rst");

    // CLKS_PER_BIT=2 instance, byte 0xFF
    cap_q.delete();
    cap_en    = 1'b1;
    tx_data2  = 8'hFF;
    tx_valid2 = 1'b1;
    step();
    tx_valid2 = 1'b0;
    repeat (FL2) step();
    check("cpb2_busy_in_stop", tx_busy2, 1'b1);
    step();
    check("cpb2_busy_off", tx_busy2, 1'b0);
    get_frame(1, CPB2, 1, v, st);
    check("cpb2_frame", v, exp_frame(8'hFF));
    check("cpb2_width", st, 1'b1);
    check("cpb2_start_2nd", cap_q[2][1], 1'b0);
    check("cpb2_d0_high", cap_q[3][1], 1'b1);
    lows = 0;
    for (int i = 1; i <= FL2; i++) if (cap_q[i][1] === 1'b0) lows++;
    check("cpb2_low_cycles", lows, (FRAME_BITS == 11) ? 4 : 2);
    cap_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
